// File: rtl/riscp_pkg.sv
// Shared types for the write-back stage.
// FSM encoding and register-index constants.
package riscp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    SETUP     = 2'd2,
    PULSE     = 2'd3
  } wb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/write_back_stage_if.sv
// Execute -> write-back retire handshake.
// Execute is the master; write-back is the slave.
interface write_back_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) ();

  logic                      ex_valid;
  logic                      ex_ready;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0]     ex_result;
  logic                      ex_reg_write;
  logic                      ex_is_load;

  modport master (
    output ex_valid,
    output ex_rd,
    output ex_result,
    output ex_reg_write,
    output ex_is_load,
    input  ex_ready
  );

  modport slave (
    input  ex_valid,
    input  ex_rd,
    input  ex_result,
    input  ex_reg_write,
    input  ex_is_load,
    output ex_ready
  );

endinterface

// File: rtl/load_timeout_counter.sv
// Counts edges spent waiting for a load ack.
// expired is high on the edge that would reach LOAD_TIMEOUT.
module load_timeout_counter #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == CW'(LOAD_TIMEOUT - 1));

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: retires instructions, fetches load data and
// sequences the register-file write strobe around stable RW/BusW.
module write_back_stage
  import riscp_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_TIMEOUT   = 255
) (
  input  logic                      clock,
  input  logic                      reset_n,
  write_back_stage_if.slave         ex,
  output logic                      mem_read_req,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [REG_ADDR_WIDTH-1:0] RW,
  output logic [DATA_WIDTH-1:0]     BusW,
  output logic                      sig_enable_write,
  output logic                      fwd_valid,
  output logic                      load_timeout_err,
  output logic [31:0]               retired_count
);

  wb_state_t r_state;
  wb_state_t w_state_nxt;

  logic [REG_ADDR_WIDTH-1:0] r_rw;
  logic [REG_ADDR_WIDTH-1:0] w_rw_nxt;
  logic [DATA_WIDTH-1:0]     r_busw;
  logic [DATA_WIDTH-1:0]     w_busw_nxt;
  logic [DATA_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     w_addr_nxt;
  logic                      r_req;
  logic                      w_req_nxt;
  logic                      r_we;
  logic                      w_we_nxt;
  logic                      r_err;
  logic                      w_err_nxt;
  logic [31:0]               r_retired;
  logic [31:0]               w_retired_nxt;

  logic w_idle;
  logic w_xfer;
  logic w_no_write;
  logic w_clear;
  logic w_enable;
  logic w_expired;

  assign w_idle     = (r_state == IDLE);
  assign w_xfer     = ex.ex_valid && w_idle;
  assign w_no_write = !ex.ex_reg_write ||
                      (ex.ex_rd == REG_ADDR_WIDTH'(REG_ZERO));

  load_timeout_counter #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) u_tmo (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (w_clear),
    .enable (w_enable),
    .expired(w_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rw_nxt      = r_rw;
    w_busw_nxt    = r_busw;
    w_addr_nxt    = r_addr;
    w_req_nxt     = r_req;
    w_we_nxt      = r_we;
    w_err_nxt     = r_err;
    w_retired_nxt = r_retired;
    w_clear       = 1'b0;
    w_enable      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          unique case (1'b1)
            w_no_write: begin
              w_retired_nxt = r_retired + 32'd1;
            end
            (!w_no_write && ex.ex_is_load): begin
              w_rw_nxt    = ex.ex_rd;
              w_addr_nxt  = ex.ex_result;
              w_req_nxt   = 1'b1;
              w_clear     = 1'b1;
              w_state_nxt = LOAD_WAIT;
            end
            (!w_no_write && !ex.ex_is_load): begin
              w_rw_nxt    = ex.ex_rd;
              w_busw_nxt  = ex.ex_result;
              w_state_nxt = SETUP;
            end
          endcase
        end
      end
      LOAD_WAIT: begin
        if (mem_ack) begin
          w_busw_nxt  = mem_rdata;
          w_req_nxt   = 1'b0;
          w_state_nxt = SETUP;
        end else begin
          w_enable = 1'b1;
          // abort drops the write entirely but still retires
          if (w_expired) begin
            w_req_nxt     = 1'b0;
            w_err_nxt     = 1'b1;
            w_retired_nxt = r_retired + 32'd1;
            w_state_nxt   = IDLE;
          end
        end
      end
      SETUP: begin
        w_we_nxt    = 1'b1;
        w_state_nxt = PULSE;
      end
      PULSE: begin
        w_we_nxt      = 1'b0;
        w_retired_nxt = r_retired + 32'd1;
        w_state_nxt   = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rw      <= '0;
      r_busw    <= '0;
      r_addr    <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_rw      <= w_rw_nxt;
      r_busw    <= w_busw_nxt;
      r_addr    <= w_addr_nxt;
      r_req     <= w_req_nxt;
      r_we      <= w_we_nxt;
      r_err     <= w_err_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign ex.ex_ready       = reset_n && w_idle;
  assign mem_read_req      = r_req;
  assign mem_addr          = r_addr;
  assign RW                = r_rw;
  assign BusW              = r_busw;
  assign sig_enable_write  = r_we;
  assign fwd_valid         = (r_state == SETUP) ||
                             (r_state == PULSE);
  assign load_timeout_err  = r_err;
  assign retired_count     = r_retired;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage.
// LOAD_TIMEOUT=4 so the abort path is short.
module tb_write_back_stage;

  logic        clock;
  logic        reset_n;
  logic        mem_read_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic        sig_enable_write;
  logic        fwd_valid;
  logic        load_timeout_err;
  logic [31:0] retired_count;

  int n_chk;
  int n_fail;
  int n_strobe;
  int strobe_snap;

  write_back_stage_if #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5)
  ) ex_if ();

  write_back_stage #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .LOAD_TIMEOUT(4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ex              (ex_if),
    .mem_read_req    (mem_read_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .RW              (RW),
    .BusW            (BusW),
    .sig_enable_write(sig_enable_write),
    .fwd_valid       (fwd_valid),
    .load_timeout_err(load_timeout_err),
    .retired_count   (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge sig_enable_write) n_strobe++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd,
                       input logic [31:0] res,
                       input logic wr,
                       input logic ld);
    ex_if.ex_valid     = 1'b1;
    ex_if.ex_rd        = rd;
    ex_if.ex_result    = res;
    ex_if.ex_reg_write = wr;
    ex_if.ex_is_load   = ld;
  endtask

  task automatic idle_in();
    ex_if.ex_valid     = 1'b0;
    ex_if.ex_reg_write = 1'b0;
    ex_if.ex_is_load   = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    n_strobe = 0;
    reset_n  = 1'b1;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    ex_if.ex_rd     = '0;
    ex_if.ex_result = '0;
    idle_in();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", ex_if.ex_ready, 0);
    chk("rst_req", mem_read_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rw", RW, 0);
    chk("rst_busw", BusW, 0);
    chk("rst_we", sig_enable_write, 0);
    chk("rst_fwd", fwd_valid, 0);
    chk("rst_err", load_timeout_err, 0);
    chk("rst_cnt", retired_count, 0);
    step();
    @(negedge clock) reset_n = 1'b1;
    step();
    chk("rel_ready", ex_if.ex_ready, 1);
    chk("rel_we", sig_enable_write, 0);
    chk("rel_fwd", fwd_valid, 0);

    // ALU write
    offer(5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    step();
    idle_in();
    chk("alu_rw", RW, 5);
    chk("alu_busw", BusW, 32'hDEADBEEF);
    chk("alu_we0", sig_enable_write, 0);
    chk("alu_fwd", fwd_valid, 1);
    chk("alu_busy", ex_if.ex_ready, 0);
    step();
    chk("alu_we1", sig_enable_write, 1);
    chk("alu_rw1", RW, 5);
    step();
    chk("alu_we2", sig_enable_write, 0);
    chk("alu_busw2", BusW, 32'hDEADBEEF);
    chk("alu_cnt", retired_count, 1);
    chk("alu_ready", ex_if.ex_ready, 1);
    chk("alu_fwd2", fwd_valid, 0);

    // load with ack three cycles after accept
    offer(5'd7, 32'h100, 1'b1, 1'b1);
    step();
    idle_in();
    chk("ld_req", mem_read_req, 1);
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_rw", RW, 7);
    chk("ld_fwd", fwd_valid, 0);
    step();
    step();
    chk("ld_req_hold", mem_read_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    chk("ld_req_drop", mem_read_req, 0);
    chk("ld_busw", BusW, 32'h12345678);
    chk("ld_we0", sig_enable_write, 0);
    step();
    chk("ld_we1", sig_enable_write, 1);
    step();
    chk("ld_we2", sig_enable_write, 0);
    chk("ld_cnt", retired_count, 2);
    chk("ld_err", load_timeout_err, 0);

    // four no-write instructions back-to-back
    strobe_snap = n_strobe;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) offer(5'd0, 32'h40 + i, 1'b1, i == 2);
      else            offer(5'd9, 32'h40 + i, 1'b0, 1'b0);
      step();
      chk("nw_ready", ex_if.ex_ready, 1);
      chk("nw_req", mem_read_req, 0);
    end
    idle_in();
    chk("nw_cnt", retired_count, 6);
    chk("nw_strobe", n_strobe, strobe_snap);
    chk("nw_busw", BusW, 32'h12345678);

    // load that times out
    offer(5'd3, 32'h200, 1'b1, 1'b1);
    step();
    idle_in();
    chk("to_req", mem_read_req, 1);
    for (int i = 0; i < 3; i++) step();
    chk("to_req3", mem_read_req, 1);
    step();
    chk("to_req4", mem_read_req, 0);
    chk("to_err", load_timeout_err, 1);
    chk("to_cnt", retired_count, 7);
    chk("to_ready", ex_if.ex_ready, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF;
    step();
    mem_ack = 1'b0;
    step();
    chk("stray_busw", BusW, 32'h12345678);
    chk("stray_fwd", fwd_valid, 0);
    chk("stray_strobe", n_strobe, strobe_snap);
    chk("stray_cnt", retired_count, 7);
    chk("stray_err", load_timeout_err, 1);

    // reset during LOAD_WAIT
    offer(5'd4, 32'h300, 1'b1, 1'b1);
    step();
    idle_in();
    chk("mr_req", mem_read_req, 1);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("mr_req0", mem_read_req, 0);
    chk("mr_addr0", mem_addr, 0);
    chk("mr_err0", load_timeout_err, 0);
    chk("mr_cnt0", retired_count, 0);
    chk("mr_rw0", RW, 0);
    @(negedge clock) reset_n = 1'b1;
    step();
    chk("mr_ready", ex_if.ex_ready, 1);
    step();
    step();
    chk("mr_strobe", n_strobe, strobe_snap);
    chk("mr_we", sig_enable_write, 0);
    chk("mr_req1", mem_read_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
